// File: rtl/hw_sum.sv
// Single-bit full adder: combinational sum/carry plus a
// clock-aligned registered copy of {Co, S}.
module hw_sum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  output logic       S,
  output logic       Co,
  output logic [1:0] sum_q
);

  // Pure gate-level path so ripple chains see no clock dependency
  assign S  = A ^ B ^ C;
  assign Co = (A & B) | (A & C) | (B & C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= 2'b00;
    end else begin
      sum_q <= {Co, S};
    end
  end

endmodule

// File: tb/tb_hw_sum.sv
// Scoreboarded bench for hw_sum: comb outputs, registered
// latency, reset behaviour and a 4-stage ripple chain.
module tb_hw_sum;

  logic       clk;
  logic       rst_n;
  logic       A, B, C;
  logic       S, Co;
  logic [1:0] sum_q;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  hw_sum dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .C    (C),
    .S    (S),
    .Co   (Co),
    .sum_q(sum_q)
  );

  logic [3:0] ch_a, ch_b, ch_s;
  logic [4:0] ch_c;
  logic [1:0] ch_q [4];

  assign ch_c[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_chain
    hw_sum u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (ch_a[i]),
      .B    (ch_b[i]),
      .C    (ch_c[i]),
      .S    (ch_s[i]),
      .Co   (ch_c[i+1]),
      .sum_q(ch_q[i])
    );
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout sim did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sum(input bit a, b, c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[1:0];
  endfunction

  // One cycle: drive at negedge, queue what the next edge must capture
  task automatic step(input bit a, b, c, input bit r);
    @(negedge clk);
    A = a; B = b; C = c; rst_n = r;
    exp_q.push_back(r ? ref_sum(a, b, c) : 2'b00);
    #5;
    check("comb", {6'd0, Co, S}, {6'd0, ref_sum(a, b, c)});
  endtask

  // Monitor: every edge with a pending expectation is compared
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sum_q", {6'd0, sum_q}, {6'd0, e});
      end
    end
  end

  initial begin
    logic [2:0] v;
    logic [4:0] tot;
    rst_n = 1'b0;
    A = 1'b0; B = 1'b0; C = 1'b0;
    ch_a = 4'd0; ch_b = 4'd0;

    // Reset with all ones: comb live, register held at 00
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Exhaustive sweep, 3 cycles per value
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      for (int k = 0; k < 3; k++)
        step(v[2], v[1], v[0], 1'b1);
    end

    // Latency: 011 then 100
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-run single-cycle reset during a sweep
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Same-edge change 001 -> 111
    step(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    A <= 1'b1; B <= 1'b1; C <= 1'b1;
    #1;
    check("same_edge_comb", {6'd0, Co, S}, 8'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Randomised run with occasional reset
    for (int i = 0; i < 60; i++) begin
      v = 3'($urandom_range(0, 7));
      step(v[2], v[1], v[0], $urandom_range(0, 9) != 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Ripple chain: 1111 + 0001 + 0
    ch_a = 4'b1111; ch_b = 4'b0001;
    #5;
    check("chain_s", {4'd0, ch_s}, 8'd0);
    check("chain_co", {7'd0, ch_c[4]}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      ch_a = 4'($urandom_range(0, 15));
      ch_b = 4'($urandom_range(0, 15));
      tot  = 5'(int'(ch_a) + int'(ch_b));
      #5;
      check("chain_rand", {3'd0, ch_c[4], ch_s}, {3'd0, tot});
    end

    repeat (3) @(posedge clk);
    #2;
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
